// File: rtl/bb_uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART transmitter among four byte sources.
// A port owns the transmitter for a whole packet; priority rotates past the owner when it ends.
module bb_uart_tx_arb #(
    parameter int unsigned TMO = 4
) (
    input  logic        bdclk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [31:0] data,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic        txen,
    output logic [7:0]  txreg,
    input  logic        txbsy,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAITB, SEND} state_t;

    state_t      state, state_n;
    logic [3:0]  gnt_n, ack_n;
    logic        txen_n, busy_n, err_n;
    logic [7:0]  txreg_n;
    logic [1:0]  ptr, ptr_n;
    logic [1:0]  owner, owner_n;
    logic [2:0]  cnt, cnt_n;
    logic        lastq, lastq_n;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;

    // Scan ptr, ptr+1, ... with 2-bit wrap so port 3 rolls over to port 0.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ack_n   = '0;
        txen_n  = 1'b0;
        txreg_n = txreg;
        busy_n  = busy;
        err_n   = err;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        lastq_n = lastq;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = pick;
                    gnt_n   = 4'b0001 << pick;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (req[owner] && !txbsy) begin
                    txreg_n = data[{owner, 3'b000} +: 8];
                    txen_n  = 1'b1;
                    ack_n   = 4'b0001 << owner;
                    lastq_n = last[owner];
                    cnt_n   = '0;
                    state_n = WAITB;
                end
            end
            WAITB: begin
                if (txbsy) begin
                    state_n = SEND;
                end else if (cnt == 3'(TMO)) begin
                    err_n   = 1'b1;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner + 2'd1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            SEND: begin
                if (!txbsy) begin
                    if (lastq) begin
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                        ptr_n   = owner + 2'd1;
                        state_n = IDLE;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge bdclk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            txen  <= 1'b0;
            txreg <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            lastq <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            txen  <= txen_n;
            txreg <= txreg_n;
            busy  <= busy_n;
            err   <= err_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            lastq <= lastq_n;
        end
    end

endmodule

// File: tb/tb_bb_uart_tx_arb.sv
// Directed bench for bb_uart_tx_arb with a behavioural transmitter holding txbsy for 10 cycles.
module tb_bb_uart_tx_arb;

    logic        bdclk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        txen;
    logic [7:0]  txreg;
    logic        txbsy;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    bit         tx_dead = 1'b0;
    logic [3:0] bcnt;

    bb_uart_tx_arb #(.TMO(4)) dut (
        .bdclk (bdclk),
        .rst   (rst),
        .req   (req),
        .last  (last),
        .data  (data),
        .gnt   (gnt),
        .ack   (ack),
        .txen  (txen),
        .txreg (txreg),
        .txbsy (txbsy),
        .busy  (busy),
        .err   (err)
    );

    always #5 bdclk = ~bdclk;

    // Transmitter model: busy rises at the edge that samples txen, stays high 10 cycles.
    always @(posedge bdclk) begin
        if (rst || tx_dead) begin
            txbsy <= 1'b0;
            bcnt  <= '0;
        end else if (txen && !txbsy) begin
            txbsy <= 1'b1;
            bcnt  <= 4'd9;
        end else if (txbsy) begin
            if (bcnt == 4'd0) txbsy <= 1'b0;
            else              bcnt  <= bcnt - 4'd1;
        end
    end

    task automatic tick();
        @(posedge bdclk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        last = '0;
        data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_txen(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (txen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy && !txbsy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (txen !== 1'b0) begin n_bad++; $display("FAIL reset_txen: got %b want 0", txen); end
        n_cmp++; if (txreg !== 8'h00) begin n_bad++; $display("FAIL reset_txreg: got %h want 00", txreg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
    endtask

    task automatic test_single_byte();
        bit ok;
        int extra;
        do_reset();
        req[1] = 1'b1; last[1] = 1'b1; data[15:8] = 8'hA5;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt: got %b want 0010", gnt); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (txen !== 1'b0) begin n_bad++; $display("FAIL single_txen_early: got %b want 0", txen); end
        tick();
        n_cmp++; if (txen !== 1'b1) begin n_bad++; $display("FAIL single_txen: got %b want 1", txen); end
        n_cmp++; if (txreg !== 8'hA5) begin n_bad++; $display("FAIL single_txreg: got %h want a5", txreg); end
        n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", ack); end
        req[1] = 1'b0;
        tick();
        n_cmp++; if (txen !== 1'b0 || ack !== 4'b0000) begin n_bad++; $display("FAIL single_pulse: got txen=%b ack=%b want 0/0000", txen, ack); end
        extra = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            tick();
            if (txen) extra++;
        end
        n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL single_end: got busy=%b gnt=%b want 0/0000", busy, gnt); end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL single_extra_txen: got %0d want 0", extra); end
        n_cmp++; if (dut.ptr !== 2'd2) begin n_bad++; $display("FAIL single_ptr: got %0d want 2", dut.ptr); end
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_idle: got busy=%b txbsy=%b want idle", busy, txbsy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] exp_gnt;
        logic [7:0] exp_byte;
        int acks[4];
        do_reset();
        for (int p = 0; p < 4; p++) acks[p] = 0;
        req = 4'b1111; last = 4'b1111; data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            exp_gnt  = 4'b0001 << (k % 4);
            exp_byte = 8'h11 * 8'((k % 4) + 1);
            wait_txen(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_txen_%0d: got no txen want txen", k); end
            n_cmp++; if (gnt !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt, exp_gnt); end
            n_cmp++; if (ack !== exp_gnt) begin n_bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, ack, exp_gnt); end
            n_cmp++; if (txreg !== exp_byte) begin n_bad++; $display("FAIL rr_txreg_%0d: got %h want %h", k, txreg, exp_byte); end
            for (int p = 0; p < 4; p++) if (ack[p] === 1'b1 && k < 4) acks[p]++;
        end
        req = '0;
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if (acks[p] != 1) begin n_bad++; $display("FAIL rr_ackcount_%0d: got %0d want 1", p, acks[p]); end
        end
        wait_idle(ok);
        n_cmp++; if (!ok || dut.ptr !== 2'd1) begin n_bad++; $display("FAIL rr_end: got idle=%b ptr=%0d want 1/1", ok, dut.ptr); end
    endtask

    task automatic test_packet_lock();
        bit ok;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        req[2] = 1'b1; last[2] = 1'b0; data[23:16] = bytes[0];
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL lock_gnt0: got %b want 0100", gnt); end
        req[0] = 1'b1; last[0] = 1'b1; data[7:0] = 8'h5A;
        for (int b = 0; b < 3; b++) begin
            wait_txen(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL lock_txen_%0d: got no txen want txen", b); end
            n_cmp++; if (txreg !== bytes[b]) begin n_bad++; $display("FAIL lock_txreg_%0d: got %h want %h", b, txreg, bytes[b]); end
            n_cmp++; if (gnt !== 4'b0100 || ack !== 4'b0100) begin n_bad++; $display("FAIL lock_owner_%0d: got gnt=%b ack=%b want 0100/0100", b, gnt, ack); end
            if (b < 2) begin
                data[23:16] = bytes[b+1];
                last[2]     = (b == 1);
            end else begin
                req[2] = 1'b0;
            end
        end
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b0001 || txreg !== 8'h5A) begin n_bad++; $display("FAIL lock_next: got ok=%b gnt=%b txreg=%h want 1/0001/5a", ok, gnt, txreg); end
        req[0] = 1'b0;
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lock_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        tx_dead = 1'b1;
        req[3] = 1'b1; last[3] = 1'b1; data[31:24] = 8'hC3;
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b1000) begin n_bad++; $display("FAIL tmo_txen: got ok=%b gnt=%b want 1/1000", ok, gnt); end
        req[3] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got err=%b want 0", err); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1", err); end
        n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL tmo_ptr: got %0d want 0", dut.ptr); end
        tx_dead = 1'b0;
        req[1] = 1'b1; last[1] = 1'b1; data[15:8] = 8'h7E;
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b0010 || txreg !== 8'h7E) begin n_bad++; $display("FAIL tmo_recover: got ok=%b gnt=%b txreg=%h want 1/0010/7e", ok, gnt, txreg); end
        req[1] = 1'b0;
        wait_idle(ok);
        n_cmp++; if (!ok || err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got idle=%b err=%b want 1/1", ok, err); end
    endtask

    task automatic test_stall();
        bit ok;
        int stray_txen;
        int bad_gnt;
        do_reset();
        req[0] = 1'b1; last[0] = 1'b0; data[7:0] = 8'h55;
        req[1] = 1'b1; last[1] = 1'b1; data[15:8] = 8'h77;
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b0001 || txreg !== 8'h55) begin n_bad++; $display("FAIL stall_first: got ok=%b gnt=%b txreg=%h want 1/0001/55", ok, gnt, txreg); end
        req[0] = 1'b0;
        stray_txen = 0;
        bad_gnt    = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (txen) stray_txen++;
            if (gnt !== 4'b0001) bad_gnt++;
        end
        n_cmp++; if (stray_txen != 0) begin n_bad++; $display("FAIL stall_txen: got %0d want 0", stray_txen); end
        n_cmp++; if (bad_gnt != 0 || busy !== 1'b1) begin n_bad++; $display("FAIL stall_hold: got badgnt=%0d busy=%b want 0/1", bad_gnt, busy); end
        req[0] = 1'b1; last[0] = 1'b1; data[7:0] = 8'h66;
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b0001 || txreg !== 8'h66) begin n_bad++; $display("FAIL stall_resume: got ok=%b gnt=%b txreg=%h want 1/0001/66", ok, gnt, txreg); end
        req[0] = 1'b0;
        wait_txen(ok);
        n_cmp++; if (!ok || gnt !== 4'b0010 || txreg !== 8'h77) begin n_bad++; $display("FAIL stall_other: got ok=%b gnt=%b txreg=%h want 1/0010/77", ok, gnt, txreg); end
        req[1] = 1'b0;
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_idle: got busy=%b want 0", busy); end
    endtask

    // Runs straight after the timeout scenario so err is set when rst arrives.
    task automatic test_reset_mid();
        bit ok;
        req[2] = 1'b1; last[2] = 1'b0; data[23:16] = 8'hAA;
        wait_txen(ok);
        req[2] = 1'b0;
        tick();
        tick();
        n_cmp++; if (!ok || busy !== 1'b1 || txbsy !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got ok=%b busy=%b txbsy=%b err=%b want 1/1/1/1", ok, busy, txbsy, err); end
        rst = 1'b1;
        tick();
        n_cmp++; if (gnt !== 4'b0000 || txen !== 1'b0) begin n_bad++; $display("FAIL rstmid_gnt: got gnt=%b txen=%b want 0000/0", gnt, txen); end
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got err=%b busy=%b want 0/0", err, busy); end
        n_cmp++; if (dut.ptr !== 2'd0 || txreg !== 8'h00) begin n_bad++; $display("FAIL rstmid_ptr: got ptr=%0d txreg=%h want 0/00", dut.ptr, txreg); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; last = '0; data = '0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_reset_mid();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
